// File: rtl/axi_fir_lite.sv
// axi_fir_lite: AXI4-Lite programmable FIR with shadow/active coefficient banks, saturation and sample counter
module axi_fir_lite #(
  parameter int NUM_TAPS = 4,
  parameter int DATA_W = 16,
  parameter int COEFF_W = 16,
  parameter logic [COEFF_W-1:0] DEFAULT_COEFF = COEFF_W'(16'h2000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        axi_awaddr,
  input  logic [2:0]         axi_awprot,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [31:0]        axi_wdata,
  input  logic [3:0]         axi_wstrb,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  output logic [1:0]         axi_bresp,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  input  logic [31:0]        axi_araddr,
  input  logic [2:0]         axi_arprot,
  input  logic               axi_arvalid,
  output logic               axi_arready,
  output logic [31:0]        axi_rdata,
  output logic [1:0]         axi_rresp,
  output logic               axi_rvalid,
  input  logic               axi_rready,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  output logic               in_ready,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out
);
  localparam int IW = $clog2(NUM_TAPS);
  localparam int PW = DATA_W + COEFF_W;
  localparam int AW = PW + IW;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic enable, pend, sticky, we, re, w_map, r_map, ctrl_we, coef_we, commit, clr_cnt, clr_sat, accept, ovf;
  logic [31:0] count, wmask, rd;
  logic [29:0] wword, rword;
  logic [IW-1:0] idx, wk, rk;
  logic [COEFF_W-1:0] wmerged;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, shv;
  logic [DATA_W-1:0] sat;
  logic signed [DATA_W-1:0] x [NUM_TAPS];
  logic signed [COEFF_W-1:0] c [NUM_TAPS];
  logic [COEFF_W-1:0] sh [NUM_TAPS];
  logic unused_ok;

  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};
  assign axi_wready = axi_awready;
  assign wword = axi_awaddr[31:2];
  assign rword = axi_araddr[31:2];
  assign we = axi_awready & axi_awvalid & axi_wvalid;
  assign re = axi_arready & axi_arvalid;
  assign w_map = wword < 30'(4 + NUM_TAPS);
  assign r_map = rword < 30'(4 + NUM_TAPS);
  assign ctrl_we = we & (wword == 30'd0) & axi_wstrb[0];
  assign commit = ctrl_we & axi_wdata[1];
  assign clr_cnt = ctrl_we & axi_wdata[2];
  assign clr_sat = ctrl_we & axi_wdata[3];
  assign coef_we = we & (wword >= 30'd3) & (wword < 30'(3 + NUM_TAPS));
  assign wk = IW'(wword - 30'd3);
  assign rk = IW'(rword - 30'd3);
  assign wmask = {{8{axi_wstrb[3]}}, {8{axi_wstrb[2]}}, {8{axi_wstrb[1]}}, {8{axi_wstrb[0]}}};
  assign wmerged = COEFF_W'((32'(sh[wk]) & ~wmask) | (axi_wdata & wmask));
  assign rd = rword == 30'd0 ? {31'b0, enable} :
              rword == 30'd1 ? {29'b0, pend, sticky, state != IDLE} :
              rword == 30'd2 ? {8'b0, 8'(COEFF_W), 8'(DATA_W), 8'(NUM_TAPS)} :
              rword == 30'(3 + NUM_TAPS) ? count :
              r_map ? 32'(sh[rk]) : '0;
  assign prod = PW'(x[idx]) * PW'(c[idx]);
  assign shv = acc >>> (COEFF_W - 1);
  assign ovf = !(&shv[AW-1:DATA_W-1]) & (|shv[AW-1:DATA_W-1]);
  assign sat = ovf ? {shv[AW-1], {(DATA_W-1){~shv[AW-1]}}} : shv[DATA_W-1:0];
  assign in_ready = (state == IDLE) & enable & !pend;
  assign accept = valid_in & in_ready;

  always_comb begin
    state_n = state == IDLE ? (accept ? MAC : IDLE) :
              state == MAC ? (idx == IW'(NUM_TAPS - 1) ? OUT : MAC) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_awready <= 1'b0;
      axi_arready <= 1'b0;
      axi_bvalid <= 1'b0;
      axi_rvalid <= 1'b0;
      axi_bresp <= 2'b00;
      axi_rresp <= 2'b00;
      axi_rdata <= '0;
    end else begin
      axi_awready <= axi_awvalid & axi_wvalid & !axi_bvalid & !axi_awready;
      axi_arready <= axi_arvalid & !axi_rvalid & !axi_arready;
      if (we) begin
        axi_bvalid <= 1'b1;
        axi_bresp <= w_map ? 2'b00 : 2'b10;
      end else if (axi_bready) axi_bvalid <= 1'b0;
      if (re) begin
        axi_rvalid <= 1'b1;
        axi_rdata <= rd;
        axi_rresp <= r_map ? 2'b00 : 2'b10;
      end else if (axi_rready) axi_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= 1'b1;
      pend <= 1'b0;
      sticky <= 1'b0;
      count <= '0;
      for (int k = 0; k < NUM_TAPS; k++) sh[k] <= DEFAULT_COEFF;
    end else begin
      if (ctrl_we) enable <= axi_wdata[0];
      pend <= commit | (pend & (state != IDLE));
      sticky <= !clr_sat & (sticky | ((state == OUT) & ovf));
      count <= clr_cnt ? '0 : count + 32'(state == OUT);
      if (coef_we) sh[wk] <= wmerged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out <= '0;
      acc <= '0;
      idx <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x[k] <= '0;
        c[k] <= DEFAULT_COEFF;
      end
    end else begin
      valid_out <= state == OUT;
      if (state == OUT) data_out <= sat;
      if ((state == IDLE) & pend)
        for (int k = 0; k < NUM_TAPS; k++) c[k] <= sh[k];
      if (accept) begin
        x[0] <= data_in;
        for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
        acc <= '0;
        idx <= '0;
      end else if (state == MAC) begin
        acc <= acc + AW'(prod);
        idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: doc/axi_fir_lite.md
# axi_fir_lite

Parametrised AXI4-Lite–controlled FIR filter: a sample-stream filter with NUM_TAPS runtime-programmable coefficients, shadow/active coefficient banks with an atomic commit, input flow control, output saturation and a processed-sample counter. It sits between a streaming data source and sink, and is configured by the system CPU over AXI4-Lite. For NUM_TAPS=4 the coefficient and counter addresses match the existing 4-tap filter (COEFF0 at 0x0C, counter at 0x1C).

## Interface
- NUM_TAPS, 4: filter length, 2..32.
- DATA_W, 16: sample width, signed Q1.(DATA_W-1).
- COEFF_W, 16: coefficient width, signed Q1.(COEFF_W-1), ≤32.
- DEFAULT_COEFF, 16'h2000: reset value of every coefficient (shadow and active).
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- axi_awaddr/awprot/awvalid/awready, axi_wdata/wstrb/wvalid/wready, axi_bresp/bvalid/bready, axi_araddr/arprot/arvalid/arready, axi_rdata/rresp/rvalid/rready: standard AXI4-Lite slave, 32-bit address and data. prot is ignored.
- valid_in  in  1  input sample strobe.
- data_in  in  DATA_W  input sample.
- in_ready  out  1  filter accepts a sample this cycle.
- valid_out  out  1  one-cycle result strobe; no backpressure.
- data_out  out  DATA_W  filtered, saturated result.

## Operation
- Register map (byte addresses, word-aligned):
  - 0x00 CTRL: bit0 enable (reset 1). bit1 commit, bit2 clr_count and bit3 clr_sat are write-1 pulses and read as 0.
  - 0x04 STATUS (RO): bit0 busy, bit1 sat_sticky, bit2 commit_pending.
  - 0x08 INFO (RO): [7:0] NUM_TAPS, [15:8] DATA_W, [23:16] COEFF_W.
  - 0x0C+4k COEFFk, for k<NUM_TAPS: shadow coefficient in [COEFF_W-1:0]. Writes honour wstrb per byte. Reads return the shadow value, zero-extended.
  - 0x0C+4·NUM_TAPS SAMPLE_COUNT (RO): 32-bit, wraps at 2^32.
- Unmapped address: a write is dropped with bresp=SLVERR (2'b10). A read returns rdata=0 with rresp=SLVERR. Otherwise the response is OKAY.
- Commit: sets commit_pending. While in IDLE with commit_pending set, all shadow coefficients are copied to the active bank in one cycle and commit_pending clears. in_ready is 0 while commit_pending=1.
- Datapath FSM:
  - IDLE: in_ready = enable & !commit_pending. When valid_in & in_ready, the delay line shifts (x0 ← data_in), acc ← 0, idx ← 0, and the FSM moves to MAC.
  - MAC: acc += x[idx]·c_active[idx], one tap per cycle. After idx = NUM_TAPS-1 the FSM moves to OUT.
  - OUT: valid_out=1 and data_out=sat(acc >>> (COEFF_W-1)). SAMPLE_COUNT increments. The FSM then returns to IDLE.
- Arithmetic:
  - Products are full-precision signed.
  - The accumulator is DATA_W+COEFF_W+clog2(NUM_TAPS) bits and never overflows.
  - The shift is arithmetic (truncation toward −∞).
  - Results are clamped to [−2^(DATA_W-1), 2^(DATA_W-1)−1]. Any clamp sets sat_sticky, which is cleared only by clr_sat.
- busy = (state ≠ IDLE).
- Clearing enable does not abort an in-flight sample; it only blocks new accepts.
- clr_count in the same cycle as an increment: the counter ends at 0.

## Timing
- Reset values: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, valid_out=0, data_out=0, in_ready=1. Delay line is 0, acc is 0, state is IDLE, SAMPLE_COUNT is 0, sat_sticky is 0, and all coefficients are DEFAULT_COEFF.
- Write channel:
  - awready and wready pulse together for one cycle when awvalid & wvalid & !bvalid. The register updates on that edge.
  - bvalid rises the next cycle and holds until bready.
  - AW without W (or W without AW) waits; it is not accepted alone.
- Read channel:
  - arready pulses one cycle when arvalid & !rvalid.
  - rvalid and rdata are registered the next cycle and held stable until rready.
- Stream:
  - A sample accepted at edge E gives valid_out high during the cycle after edge E+NUM_TAPS+1, i.e. latency NUM_TAPS+2 cycles.
  - in_ready is 0 from E until the FSM re-enters IDLE.
  - Throughput is one sample per NUM_TAPS+2 cycles.
- A register write and a commit issued during MAC do not disturb the current sample. The commit takes effect at the first IDLE cycle.
- Reset asserted mid-operation: everything returns to reset values immediately. No valid_out is produced for the interrupted sample.

## Test plan
- Reset, then read 0x0C, 0x08 and 0x1C → 0x00002000, 0x00101004 and 0x00000000, all with rresp=OKAY.
- Default coefficients, four inputs of 0x7FFF → outputs 0x1FFF, 0x3FFF, 0x5FFF, 0x7FFF. Each valid_out comes 6 cycles after its accept. in_ready is 0 between accepts. SAMPLE_COUNT reads 4.
- Write coefficients 0x2000, 0xE000, 0xE000, 0x2000 without commit, then send 0x7FFF → output 0x1FFF (old bank) and STATUS.commit_pending=0. Then commit and send four samples of 0x7FFF → the fourth output is 0x0000.
- All coefficients 0x7FFF and two inputs of 0x8000 → second output 0x8000 and STATUS bit1 = 1. Write CTRL bit3, then STATUS bit1 = 0.
- Write to 0x40 → bresp=SLVERR and no register changes. Read 0x40 → rdata=0, rresp=SLVERR. Hold bready/rready low for 5 cycles → bvalid/rvalid and rdata stay stable.
- Clear enable, then hold valid_in high → in_ready=0 and no valid_out. Assert rst_n=0 during MAC → valid_out stays 0 and COEFF0 reads 0x2000 after reset.
